// File: rtl/perf_event_counter.sv
// perf_event_counter: per-cycle retirement/cache event counter bank with a registered read port.
// Optional build macro PERF_SATURATE_EN: counters saturate and a sticky saturation flag appears at status bit3.
module perf_event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             halt,
  input  logic             reg_wrt,
  input  logic             mem_wrt,
  input  logic             stall,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  input  logic             rd_req,
  input  logic [2:0]       rd_sel,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             frozen,
  output logic             err
);

  localparam int NUM_CNT = 7;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {RUN, FROZEN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   counters [NUM_CNT];
  logic [NUM_CNT-1:0] events;
  logic               counted;
  logic               protocolErr;
  logic               satFlag;
  logic [CNT_W-1:0]   statusWord;
  logic [CNT_W-1:0]   readValue;

  assign counted     = (state == RUN) && en && !clr;
  assign events      = {stall, dcache_hit, dcache_req, icache_hit, icache_req,
                        halt | reg_wrt | mem_wrt, 1'b1};
  assign protocolErr = (icache_hit & ~icache_req) | (dcache_hit & ~dcache_req);
  assign frozen      = (state == FROZEN);

`ifdef PERF_SATURATE_EN
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

  logic satNext;

  function automatic logic [CNT_W-1:0] nextCount(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + CNT_ONE;
  endfunction

  // The flag rises on the edge where any incrementing counter lands on all-ones.
  always_comb begin
    satNext = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (events[i] && (counters[i] >= CNT_NEAR_MAX)) satNext = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) satFlag <= 1'b0;
    else if (counted && satNext) satFlag <= 1'b1;
  end
`else
  function automatic logic [CNT_W-1:0] nextCount(input logic [CNT_W-1:0] value);
    return value + CNT_ONE;
  endfunction

  assign satFlag = 1'b0;
`endif

  always_comb begin
    statusWord      = '0;
    statusWord[3:0] = {satFlag, en, err, frozen};
    readValue       = statusWord;
    if (rd_sel != 3'd7) readValue = counters[rd_sel];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < NUM_CNT; i++) counters[i] <= '0;
    end else if (counted) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (events[i]) counters[i] <= nextCount(counters[i]);
      end
    end
  end

  // Reads sample the pre-edge counters, so a clear or event in the same cycle is not visible yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= readValue;
      if (clr) begin
        state <= RUN;
        err   <= 1'b0;
      end else if (counted) begin
        if (halt) state <= FROZEN;
        if (protocolErr) err <= 1'b1;
      end
    end
  end

endmodule
